// File: rtl/store_mem_ctrl.sv
// Read-modify-write store controller: sw writes directly, sb/sh read the old word and merge the low lane.
// Optional STORE_ALIGN_CHECK_EN rejects misaligned sw/sh with err=1 and no memory write.
module store_mem_ctrl #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  store_type,
    input  logic [31:0] addr,
    input  logic [31:0] B_in,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [31:0] MDR_out,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] TYPE_SW  = 2'b00;
    localparam logic [1:0] TYPE_SB  = 2'b01;
    localparam logic [1:0] TYPE_ILL = 2'b11;
    localparam logic [3:0] LAT      = 4'(MEM_LATENCY);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] b_q, b_d;
    logic [1:0]  type_q, type_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        misaligned;

    always_comb begin
`ifdef STORE_ALIGN_CHECK_EN
        misaligned = ((store_type == 2'b10) && addr[0]) ||
                     ((store_type == TYPE_SW) && (addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
    end

    // Outputs are computed for the upcoming state so they come straight from flops.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        b_d     = b_q;
        type_d  = type_q;
        cnt_d   = cnt_q;
        mdr_d   = mdr_q;
        err_d   = err_q;
        wdata_d = 32'd0;
        wr_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d = addr;
                    b_d    = B_in[15:0];
                    type_d = store_type;
                    err_d  = 1'b0;
                    if ((store_type == TYPE_ILL) || misaligned) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else if (store_type == TYPE_SW) begin
                        wr_d    = 1'b1;
                        busy_d  = 1'b1;
                        wdata_d = B_in;
                        state_d = WRITE;
                    end else begin
                        busy_d  = 1'b1;
                        cnt_d   = LAT;
                        state_d = READ;
                    end
                end
            end
            READ: begin
                busy_d = 1'b1;
                if (cnt_q <= 4'd1) begin
                    mdr_d   = mem_rdata;
                    cnt_d   = 4'd0;
                    wr_d    = 1'b1;
                    // Merges always land in the low lane, whatever addr[1:0] is.
                    wdata_d = (type_q == TYPE_SB) ? {mem_rdata[31:8], b_q[7:0]}
                                                  : {mem_rdata[31:16], b_q};
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WRITE: begin
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            b_q     <= 16'd0;
            type_q  <= 2'd0;
            cnt_q   <= 4'd0;
            mdr_q   <= 32'd0;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            b_q     <= b_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
            mdr_q   <= mdr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wr    = wr_q;
    assign mem_wdata = wdata_q;
    assign MDR_out   = mdr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_store_mem_ctrl.sv
// Scoreboard bench for store_mem_ctrl: one instance at MEM_LATENCY=1, one at MEM_LATENCY=3.
// Expected writes and completions are queued at start time and popped when the DUT produces them.
module tb_store_mem_ctrl;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic err;
        int   cyc;
    } dn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1, start3;
    logic [1:0]  store_type;
    logic [31:0] addr, B_in, mem_rdata;
    logic [31:0] mem_addr1, mem_wdata1, mdr1, mem_addr3, mem_wdata3, mdr3;
    logic        mem_wr1, busy1, done1, err1, mem_wr3, busy3, done3, err3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busyCnt3 = 0;
    wr_t wrQ1[$], wrQ3[$];
    dn_t dnQ1[$], dnQ3[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    store_mem_ctrl #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .store_type(store_type),
        .addr(addr), .B_in(B_in), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr1), .mem_wr(mem_wr1), .mem_wdata(mem_wdata1),
        .MDR_out(mdr1), .busy(busy1), .done(done1), .err(err1)
    );

    store_mem_ctrl #(.MEM_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .store_type(store_type),
        .addr(addr), .B_in(B_in), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr3), .mem_wr(mem_wr3), .mem_wdata(mem_wdata3),
        .MDR_out(mdr3), .busy(busy3), .done(done3), .err(err3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference behaviour: what a request should produce, given the current memory word.
    task automatic pushExpect(input int which, input int s, input logic [1:0] t,
                              input logic [31:0] a, input logic [31:0] b);
        int  lat;
        logic bad;
        logic [31:0] data;
        wr_t w;
        dn_t d;
        lat = (which == 3) ? 3 : 1;
        bad = (t == 2'b11);
`ifdef STORE_ALIGN_CHECK_EN
        if ((t == 2'b10 && a[0]) || (t == 2'b00 && a[1:0] != 2'b00)) bad = 1'b1;
`endif
        if (bad) begin
            d.err = 1'b1;
            d.cyc = s + 1;
        end else begin
            case (t)
                2'b00:   begin data = b;                               w.cyc = s + 1;       end
                2'b01:   begin data = {mem_rdata[31:8], b[7:0]};      w.cyc = s + lat + 1; end
                default: begin data = {mem_rdata[31:16], b[15:0]};    w.cyc = s + lat + 1; end
            endcase
            w.addr = a;
            w.data = data;
            d.err  = 1'b0;
            d.cyc  = w.cyc + 1;
            if (which == 3) wrQ3.push_back(w); else wrQ1.push_back(w);
        end
        if (which == 3) dnQ3.push_back(d); else dnQ1.push_back(d);
    endtask

    task automatic applyStimulus(input int which, input logic [1:0] t,
                                 input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        store_type = t;
        addr       = a;
        B_in       = b;
        if (which == 3) start3 = 1'b1; else start1 = 1'b1;
        pushExpect(which, cyc, t, a, b);
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic waitDone(input int which);
        int n;
        n = 0;
        while (n < 40 && ((which == 3) ? (wrQ3.size() + dnQ3.size()) : (wrQ1.size() + dnQ1.size())) != 0) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput((which == 3) ? "pending3" : "pending1",
                    (which == 3) ? 32'(wrQ3.size() + dnQ3.size()) : 32'(wrQ1.size() + dnQ1.size()), 32'd0);
        if (which == 3) begin wrQ3.delete(); dnQ3.delete(); end
        else begin wrQ1.delete(); dnQ1.delete(); end
    endtask

    always @(negedge clk) begin : mon1
        wr_t w;
        dn_t d;
        if (mem_wr1 === 1'b1) begin
            if (wrQ1.size() == 0) checkOutput("unexp_wr1", {31'd0, mem_wr1}, 32'd0);
            else begin
                w = wrQ1.pop_front();
                checkOutput("wr1_addr", mem_addr1, w.addr);
                checkOutput("wr1_data", mem_wdata1, w.data);
                checkOutput("wr1_cyc", 32'(cyc), 32'(w.cyc));
            end
        end else if (mem_wdata1 !== 32'd0) begin
            checkOutput("idle_wdata1", mem_wdata1, 32'd0);
        end
        if (done1 === 1'b1) begin
            if (dnQ1.size() == 0) checkOutput("unexp_done1", {31'd0, done1}, 32'd0);
            else begin
                d = dnQ1.pop_front();
                checkOutput("done1_err", {31'd0, err1}, {31'd0, d.err});
                checkOutput("done1_cyc", 32'(cyc), 32'(d.cyc));
            end
        end
    end

    always @(negedge clk) begin : mon3
        wr_t w;
        dn_t d;
        if (busy3 === 1'b1) busyCnt3 <= busyCnt3 + 1;
        if (mem_wr3 === 1'b1) begin
            if (wrQ3.size() == 0) checkOutput("unexp_wr3", {31'd0, mem_wr3}, 32'd0);
            else begin
                w = wrQ3.pop_front();
                checkOutput("wr3_addr", mem_addr3, w.addr);
                checkOutput("wr3_data", mem_wdata3, w.data);
                checkOutput("wr3_cyc", 32'(cyc), 32'(w.cyc));
            end
        end
        if (done3 === 1'b1) begin
            if (dnQ3.size() == 0) checkOutput("unexp_done3", {31'd0, done3}, 32'd0);
            else begin
                d = dnQ3.pop_front();
                checkOutput("done3_err", {31'd0, err3}, {31'd0, d.err});
                checkOutput("done3_cyc", 32'(cyc), 32'(d.cyc));
            end
        end
    end

    initial begin
        reset = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        store_type = 2'b00;
        addr = 32'd0;
        B_in = 32'd0;
        mem_rdata = 32'd0;
        #1;
        checkOutput("rst_mem_wr", {31'd0, mem_wr1}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy1}, 32'd0);
        checkOutput("rst_done", {31'd0, done1}, 32'd0);
        checkOutput("rst_err", {31'd0, err1}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr1, 32'd0);
        checkOutput("rst_mdr", mdr1, 32'd0);
        checkOutput("rst_wdata", mem_wdata1, 32'd0);
        checkOutput("rst_busy3", {31'd0, busy3}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // sw, sb, illegal on the single-cycle-latency instance
        applyStimulus(1, 2'b00, 32'h40, 32'hDEADBEEF);
        waitDone(1);
        checkOutput("sw_addr_hold", mem_addr1, 32'h40);
        mem_rdata = 32'h11223344;
        applyStimulus(1, 2'b01, 32'h80, 32'h123456AB);
        waitDone(1);
        checkOutput("sb_mdr", mdr1, 32'h11223344);
        applyStimulus(1, 2'b11, 32'h44, 32'h55);
        waitDone(1);
        checkOutput("ill_err_hold", {31'd0, err1}, 32'd1);

        // start held high through READ/WRITE/DONE must not spawn a second write
        mem_rdata = 32'hA5A5A5A5;
        applyStimulus(1, 2'b10, 32'h90, 32'h00001234);
        start1 = 1'b1;
        store_type = 2'b00;
        addr = 32'hF0;
        repeat (3) @(negedge clk);
        start1 = 1'b0;
        waitDone(1);

        // misaligned requests
        mem_rdata = 32'hCAFEF00D;
        applyStimulus(1, 2'b10, 32'h81, 32'h0000BEEF);
        waitDone(1);
        applyStimulus(1, 2'b00, 32'h42, 32'h12345678);
        waitDone(1);
        applyStimulus(1, 2'b01, 32'h83, 32'h000000EE);
        waitDone(1);

        for (int i = 0; i < 8; i++) begin
            mem_rdata = $urandom;
            applyStimulus(1, 2'($urandom_range(0, 3)), $urandom, $urandom);
            waitDone(1);
        end

        // sh at MEM_LATENCY=3: four busy cycles, done at cycle+5
        mem_rdata = 32'hCAFEF00D;
        busyCnt3 = 0;
        applyStimulus(3, 2'b10, 32'h100, 32'h0000BEEF);
        waitDone(3);
        checkOutput("sh3_busy_cycles", 32'(busyCnt3), 32'd4);
        checkOutput("sh3_mdr", mdr3, 32'hCAFEF00D);

        // reset in the middle of an sb read aborts it; sw right after release runs normally
        mem_rdata = 32'h11223344;
        applyStimulus(3, 2'b01, 32'h80, 32'h123456AB);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_mem_wr", {31'd0, mem_wr3}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy3}, 32'd0);
        checkOutput("midrst_addr", mem_addr3, 32'd0);
        wrQ3.delete();
        dnQ3.delete();
        @(negedge clk);
        reset = 1'b0;
        store_type = 2'b00;
        addr = 32'h10;
        B_in = 32'h1;
        start3 = 1'b1;
        pushExpect(3, cyc, 2'b00, 32'h10, 32'h1);
        @(negedge clk);
        start3 = 1'b0;
        waitDone(3);
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_mem_ctrl.md
STORE_MEM_CTRL -- requirements
Module: store_mem_ctrl

Interface
REQ-001 SHALL have parameter: MEM_LATENCY, 1, memory read latency in cycles; legal range 1..15.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port: store_type  input  2  00 sw, 01 sb, 10 sh, 11 illegal.
REQ-006 SHALL have port: addr  input  32  store address; latched on start.
REQ-007 SHALL have port: B_in  input  32  store data from register B; latched on start.
REQ-008 SHALL have port: mem_rdata  input  32  memory read data, valid MEM_LATENCY cycles after mem_addr is presented.
REQ-009 SHALL have port: mem_addr  output  32  memory address.
REQ-010 SHALL have port: mem_wr  output  1  memory write strobe.
REQ-011 SHALL have port: mem_wdata  output  32  memory write data.
REQ-012 SHALL have port: MDR_out  output  32  captured read word (old memory contents).
REQ-013 SHALL have port: busy  output  1  high in READ and WRITE.
REQ-014 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port: err  output  1  completion status; valid while done=1.

Function
REQ-016 SHALL implement states IDLE, READ, WRITE, DONE, with outputs decoded only from state and internal registers (Moore; no input-to-output combinational path).
REQ-017 IDLE with start=1 SHALL latch addr, B_in and store_type, then go to WRITE for sw, READ for sb/sh, and DONE with err=1 for 11.
REQ-018 start SHALL be ignored in READ, WRITE and DONE; no queuing.
REQ-019 READ SHALL last exactly MEM_LATENCY cycles: a 4-bit counter is loaded on entry, mem_addr=latched addr, mem_wr=0; on the last READ cycle's edge, mem_rdata is captured into MDR_out and the state goes to WRITE.
REQ-020 WRITE SHALL last exactly one cycle, with mem_wr=1 and mem_addr=latched addr, then go to DONE.
REQ-021 mem_wdata in WRITE SHALL be: sw = B; sb = {MDR_out[31:8], B[7:0]}; sh = {MDR_out[31:16], B[15:0]}.
REQ-022 Byte and halfword merges SHALL always target the low lane regardless of addr[1:0].
REQ-023 DONE SHALL last one cycle, with done=1, err held at its status value, then return to IDLE.
REQ-024 Latency from the start-sampling edge to the done cycle SHALL be 2 cycles for sw, MEM_LATENCY+2 for sb/sh, and 1 for illegal.
REQ-025 Outside WRITE: mem_wr=0 and mem_wdata=0. Outside READ/WRITE: mem_addr holds the last latched addr.
REQ-026 err SHALL be cleared on each accepted start unless set by REQ-017 or REQ-030.

Reset
REQ-027 Asserting reset SHALL immediately force IDLE, mem_wr=0, busy=0, done=0, err=0, mem_addr=0, MDR_out=0 and counter=0, independent of clk.
REQ-028 Reset asserted mid-READ or mid-WRITE SHALL abort the operation with no further mem_wr pulse after release.
REQ-029 On the first rising clk edge after reset deasserts, a start SHALL be accepted normally.

Configuration
REQ-030 With STORE_ALIGN_CHECK_EN defined, a misaligned request (sh with addr[0]=1; sw with addr[1:0]!=0) SHALL go IDLE->DONE with err=1 and no mem_wr; sb is never misaligned.
REQ-031 Without STORE_ALIGN_CHECK_EN, no alignment check SHALL be performed, and misaligned requests SHALL proceed to the latched addr unchanged.

Verification (MEM_LATENCY=1 unless noted)
REQ-032 sw: addr=0x40, B=0xDEADBEEF -> cycle+1: mem_wr=1, mem_addr=0x40, mem_wdata=0xDEADBEEF; cycle+2: done=1, err=0.
REQ-033 sb: addr=0x80, B=0x123456AB, memory=0x11223344 -> MDR_out=0x11223344; write 0x112233AB at cycle+2; done at cycle+3.
REQ-034 sh with MEM_LATENCY=3: memory=0xCAFEF00D, B=0x0000BEEF -> busy for 4 cycles; single write 0xCAFEBEEF; done at cycle+5.
REQ-035 store_type=11 -> no mem_wr; done=1, err=1 at cycle+1. A start pulse during busy -> ignored, exactly one write observed.
REQ-036 Reset raised during sb READ -> mem_wr=0 and busy=0 immediately; no write occurs; a following sw of 0x1 to 0x10 completes normally.
REQ-037 sh to addr=0x81 -> with STORE_ALIGN_CHECK_EN: err=1 and no write; without it: write to 0x81 with low-halfword merge.
